// File: rtl/cpu_mul_pkg.sv
// Shared widths, op encodings and sequencer states for the CPU M-stage multiplier.
package cpu_mul_pkg;

  localparam int MUL_HALF_W = 16;
  localparam int MUL_W      = 32;
  localparam int MUL_MID_W  = 34;

  typedef enum logic [1:0] {
    MUL_OP_MUL = 2'd0,
    MUL_OP_XUU = 2'd1,
    MUL_OP_XSS = 2'd2,
    MUL_OP_XSU = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISS1,
    ST_CAP1,
    ST_ISS2,
    ST_CAP2,
    ST_DONE
  } mul_state_e;

endpackage

// File: rtl/cpu_mul_pp_sum.sv
// Combinational summation of the 16x16 cell's partial products into the low
// word (pass 1) or the signed/unsigned high word (pass 2, CPU_MUL_HIGH_EN only).
module cpu_mul_pp_sum
  import cpu_mul_pkg::*;
(
  input  logic [MUL_W-1:0]     p1_i,
  input  logic [MUL_W-1:0]     p2_i,
  input  logic [MUL_W-1:0]     p3_i,
`ifdef CPU_MUL_HIGH_EN
  input  logic [MUL_MID_W-1:0] mid_i,
  input  logic [MUL_W-1:0]     a_i,
  input  logic [MUL_W-1:0]     b_i,
  input  mul_op_e              op_i,
  input  logic                 pass2_i,
  output logic [MUL_MID_W-1:0] mid_o,
`endif
  output logic [MUL_W-1:0]     result_o
);

  logic [MUL_W:0] s;
  logic [MUL_W:0] lo_sum;

  assign s      = {1'b0, p2_i} + {1'b0, p3_i};
  assign lo_sum = {1'b0, p1_i} + {1'b0, s[MUL_HALF_W-1:0], {MUL_HALF_W{1'b0}}};

`ifdef CPU_MUL_HIGH_EN
  logic [MUL_MID_W-1:0] hi_full;
  logic [MUL_W-1:0]     hi;
  logic [1:0]           unused_hi_top;
  logic                 a_neg;
  logic                 b_neg;

  // Upper half of the cross sum plus the carry lost when forming the low word.
  assign mid_o = {{(MUL_MID_W-MUL_HALF_W-1){1'b0}}, s[MUL_W:MUL_HALF_W]}
               + {{(MUL_MID_W-1){1'b0}}, lo_sum[MUL_W]};

  assign hi_full       = {2'b00, p1_i} + mid_i;
  assign unused_hi_top = hi_full[MUL_MID_W-1:MUL_W];

  // Two's-complement correction: a negative signed operand contributes -2^32 * other.
  assign a_neg = (op_i == MUL_OP_XSS || op_i == MUL_OP_XSU) && a_i[MUL_W-1];
  assign b_neg = (op_i == MUL_OP_XSS) && b_i[MUL_W-1];
  assign hi    = hi_full[MUL_W-1:0] - (a_neg ? b_i : '0) - (b_neg ? a_i : '0);

  assign result_o = pass2_i ? hi : lo_sum[MUL_W-1:0];
`else
  logic [MUL_HALF_W+1:0] unused_upper;

  assign unused_upper = {s[MUL_W:MUL_HALF_W], lo_sum[MUL_W]};
  assign result_o     = lo_sum[MUL_W-1:0];
`endif

endmodule

// File: rtl/cpu_mul_seq.sv
// Multiply sequencer: drives the 16x16 partial-product cell over one pass (MUL)
// or two passes (MULX*, only when CPU_MUL_HIGH_EN is defined) and returns the word.
module cpu_mul_seq
  import cpu_mul_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [MUL_W-1:0] req_src1,
  input  logic [MUL_W-1:0] req_src2,
  input  logic [1:0]       req_op,
  output logic [MUL_W-1:0] cell_src1,
  output logic [MUL_W-1:0] cell_src2,
  output logic             cell_en,
  input  logic [MUL_W-1:0] cell_p1,
  input  logic [MUL_W-1:0] cell_p2,
  input  logic [MUL_W-1:0] cell_p3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [MUL_W-1:0] rsp_result
);

  mul_state_e       state_q, state_d;
  logic [MUL_W-1:0] cell_src1_q, cell_src1_d;
  logic [MUL_W-1:0] cell_src2_q, cell_src2_d;
  logic             cell_en_q, cell_en_d;
  logic [MUL_W-1:0] result_q, result_d;
  logic [MUL_W-1:0] pp_result;

`ifdef CPU_MUL_HIGH_EN
  logic [MUL_W-1:0]     a_q, a_d;
  logic [MUL_W-1:0]     b_q, b_d;
  mul_op_e              op_q, op_d;
  logic [MUL_MID_W-1:0] mid_q, mid_d;
  logic [MUL_MID_W-1:0] pp_mid;
`else
  logic [1:0] unused_op;
  assign unused_op = req_op;
`endif

  cpu_mul_pp_sum u_pp_sum (
    .p1_i     (cell_p1),
    .p2_i     (cell_p2),
    .p3_i     (cell_p3),
`ifdef CPU_MUL_HIGH_EN
    .mid_i    (mid_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .pass2_i  (state_q == ST_CAP2),
    .mid_o    (pp_mid),
`endif
    .result_o (pp_result)
  );

  // NOTE: every next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cell_src1_d = cell_src1_q;
    cell_src2_d = cell_src2_q;
    cell_en_d   = 1'b0;
    result_d    = result_q;
`ifdef CPU_MUL_HIGH_EN
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    mid_d = mid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cell_src1_d = req_src1;
          cell_src2_d = req_src2;
          cell_en_d   = 1'b1;
          state_d     = ST_ISS1;
`ifdef CPU_MUL_HIGH_EN
          a_d  = req_src1;
          b_d  = req_src2;
          op_d = mul_op_e'(req_op);
`endif
        end
      end
      ST_ISS1: state_d = ST_CAP1;
      ST_CAP1: begin
`ifdef CPU_MUL_HIGH_EN
        mid_d = pp_mid;
        if (op_q == MUL_OP_MUL) begin
          result_d = pp_result;
          state_d  = ST_DONE;
        end else begin
          // Second pass reuses the cell's lo*lo product slot for a_hi*b_hi.
          cell_src1_d = {{MUL_HALF_W{1'b0}}, a_q[MUL_W-1:MUL_HALF_W]};
          cell_src2_d = {{MUL_HALF_W{1'b0}}, b_q[MUL_W-1:MUL_HALF_W]};
          cell_en_d   = 1'b1;
          state_d     = ST_ISS2;
        end
`else
        result_d = pp_result;
        state_d  = ST_DONE;
`endif
      end
`ifdef CPU_MUL_HIGH_EN
      ST_ISS2: state_d = ST_CAP2;
      ST_CAP2: begin
        result_d = pp_result;
        state_d  = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cell_src1_q <= '0;
      cell_src2_q <= '0;
      cell_en_q   <= 1'b0;
      result_q    <= '0;
`ifdef CPU_MUL_HIGH_EN
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MUL_OP_MUL;
      mid_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cell_src1_q <= cell_src1_d;
      cell_src2_q <= cell_src2_d;
      cell_en_q   <= cell_en_d;
      result_q    <= result_d;
`ifdef CPU_MUL_HIGH_EN
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      mid_q <= mid_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = result_q;
  assign cell_src1  = cell_src1_q;
  assign cell_src2  = cell_src2_q;
  assign cell_en    = cell_en_q;

endmodule

// File: doc/cpu_mul_seq.md
# cpu_mul_seq

Multiply sequencer for the CPU M stage. Accepts a 32x32 multiply request, drives the 16x16 partial-product multiplier cell over one or two passes, and sums the returned partial products. It returns a 32-bit result over a valid/ready handshake. It sits between the E-stage operand latch (upstream) and the multiplier cell (downstream), and consumes the cell's three partial-product outputs.

## Interface
- No parameters; widths are fixed constants from `cpu_mul_pkg`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_src1`, `req_src2`  in  32 each  operands.
- `req_op`  in  2  operation: 0 MUL, 1 MULXUU, 2 MULXSS, 3 MULXSU.
- `cell_src1`, `cell_src2`  out  32 each  operands to the cell.
- `cell_en`  out  1  cell register enable.
- `cell_p1`, `cell_p2`, `cell_p3`  in  32 each  partial products:
  - `cell_p1` = a_lo*b_lo
  - `cell_p2` = a_lo*b_hi
  - `cell_p3` = a_hi*b_lo
  - valid the cycle after `cell_en` is high.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  32  product word.

## Operation
- Reset values:
  - state = IDLE.
  - `rsp_valid`, `cell_en`, `cell_src1`, `cell_src2`, `rsp_result` and all internal registers = 0.
  - `req_ready` = 1.
- States: IDLE, ISS1, CAP1, ISS2, CAP2, DONE.
- IDLE → ISS1 on `req_valid`. Operands and op are latched on that edge.
- ISS1:
  - `cell_src1` = A, `cell_src2` = B, `cell_en` = 1.
  - Always → CAP1.
- CAP1:
  - s = p2 + p3, computed at 33 bits.
  - Low accumulator lo = p1 + (s << 16), mod 2^32.
  - mid = s >> 16, plus the carry out of the lo addition; held in a 34-bit register.
  - If op = MUL, latch `rsp_result` = lo and go to DONE. Otherwise go to ISS2.
- ISS2:
  - `cell_src1` = {16'h0, A[31:16]}, `cell_src2` = {16'h0, B[31:16]}, `cell_en` = 1.
  - Always → CAP2.
- CAP2:
  - hi = p1 + mid, mod 2^32.
  - If A is signed (MULXSS, MULXSU) and A[31] = 1, subtract B.
  - If B is signed (MULXSS) and B[31] = 1, subtract A.
  - Latch `rsp_result` = hi and go to DONE.
- DONE:
  - `rsp_valid` = 1 and `rsp_result` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `cell_en` = 0 outside the ISS states, so the cell holds its products.
- `req_ready` is low in every state except IDLE.
- No new request is accepted in the same cycle as a response handshake.
- Reset asserted mid-operation aborts the operation immediately and asynchronously. No response is produced.

## Timing
- Request handshake at edge T.
- MUL: ISS1 T..T+1, CAP1 T+1..T+2, `rsp_valid` high from after edge T+2.
- MULX*: `rsp_valid` high from after edge T+4.
- `rsp_valid` stays high indefinitely while `rsp_ready` is 0 (backpressure).
- The next request can be accepted 1 cycle after the response handshake at the earliest.
- `cell_src*` and `cell_en` are registered outputs and change only on clock edges.

## Configuration
- Macro: `CPU_MUL_HIGH_EN`.
- Defined:
  - All four ops are supported.
  - ISS2 and CAP2 exist, along with the mid register and the sign correction.
- Undefined:
  - `req_op` is ignored and every request is treated as MUL.
  - ISS2, CAP2, the mid register and the sign-correction logic are not built.
  - Latency is always the MUL figure.

## Structure
- `cpu_mul_pkg` holds:
  - op encodings: `MUL_OP_MUL`, `MUL_OP_XUU`, `MUL_OP_XSS`, `MUL_OP_XSU`;
  - the state enum;
  - `MUL_HALF_W` = 16 and `MUL_W` = 32.
- One sub-module, `cpu_mul_pp_sum`: combinational partial-product summation.
  - Inputs: p1, p2, p3, the mid input, A, B, op, and a pass selector.
  - Outputs: the lo/mid results for pass 1 and the hi result for pass 2.
  - The FSM and all registers live in `cpu_mul_seq`.
- The bench instantiates the real multiplier cell as the downstream model.

## Test plan
- MUL: A = 0x0001_0003, B = 0x0002_0005 → `rsp_result` = 0x000B_000F, `rsp_valid` 3 cycles after accept, `cell_en` high for exactly 1 cycle.
- MUL wrap: A = B = 0xFFFF_FFFF → `rsp_result` = 0x0000_0001.
- MULXUU (macro on): A = B = 0xFFFF_FFFF → `rsp_result` = 0xFFFF_FFFE, `rsp_valid` 5 cycles after accept.
- MULXSS with A = 0xFFFF_FFFF (-1), B = 0x0000_0002 → 0xFFFF_FFFF. MULXSU with the same operands → 0xFFFF_FFFF. MULXUU with the same operands → 0x0000_0001.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles → `rsp_valid` and `rsp_result` stable, `req_ready` = 0 throughout. Release → back in IDLE next cycle.
- Reset pulse during ISS2 → all outputs return to reset values asynchronously, no response. A following MUL request completes correctly.
